// File: rtl/shift_seq.sv
// -----------------------------------------------------------------------------
// shift_seq
// Multi-cycle shifter. It accepts one request at a time and moves a working
// register one bit position per clock for count_i cycles. It then presents
// the result for one cycle with done_o. The result stays on res_o/cout_o
// until the next request is accepted.
//
// Build option:
//   SHIFT_SEQ_ASR_EN  When defined, op 3'b100 performs an arithmetic shift
//                     right. When undefined, op 3'b100 behaves as SHL and no
//                     sign-fill path is built.
//
// Ports:
//   clk_i    : clock, all state changes on the rising edge
//   rst_ni   : synchronous active-low reset
//   start_i  : request, taken only while ready_o is high
//   op_i     : 000 SHL, 001 SHR, 010 ROL, 011 ROR, 100 ASR, others as SHL
//   rs_i     : operand, captured on acceptance
//   count_i  : shift amount, captured on acceptance
//   ready_o  : a request can be accepted this cycle (IDLE or DONE)
//   busy_o   : a shift is in progress (SHIFT)
//   done_o   : one-cycle pulse, res_o/cout_o valid (DONE)
//   res_o    : shifted result
//   cout_o   : last bit shifted out (0 for rotates and count 0)
// -----------------------------------------------------------------------------
module shift_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] rs_i,
    input  logic [CNT_W-1:0] count_i,
    output logic             ready_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] res_o,
    output logic             cout_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_r,  state_nxt_s;
    logic [WIDTH-1:0] work_r,   work_nxt_s;
    logic [CNT_W-1:0] cnt_r,    cnt_nxt_s;
    logic [2:0]       op_r,     op_nxt_s;
    logic             cout_r,   cout_nxt_s;
    logic             ready_r,  busy_r, done_r;
    logic             accept_s;
    logic [WIDTH:0]   step_s;

    // One-position move of the working word. The return value is {bit_out, word}.
    // Reserved codes (and 3'b100 when ASR is not built) fall into the SHL arm.
    function automatic logic [WIDTH:0] shift_step(input logic [2:0]       op,
                                                  input logic [WIDTH-1:0] w);
        logic [WIDTH:0] r;
        case (op)
            3'b001:  r = {w[0], 1'b0, w[WIDTH-1:1]};              // SHR
            3'b010:  r = {1'b0, w[WIDTH-2:0], w[WIDTH-1]};        // ROL
            3'b011:  r = {1'b0, w[0], w[WIDTH-1:1]};              // ROR
`ifdef SHIFT_SEQ_ASR_EN
            3'b100:  r = {w[0], w[WIDTH-1], w[WIDTH-1:1]};        // ASR
`endif
            default: r = {w[WIDTH-1], w[WIDTH-2:0], 1'b0};        // SHL
        endcase
        return r;
    endfunction

    assign accept_s = start_i & ready_r;
    assign step_s   = shift_step(op_r, work_r);

    // Next-state and datapath update for the IDLE/SHIFT/DONE sequencer.
    always_comb begin
        state_nxt_s = state_r;
        work_nxt_s  = work_r;
        cnt_nxt_s   = cnt_r;
        op_nxt_s    = op_r;
        cout_nxt_s  = cout_r;
        case (state_r)
            IDLE, DONE: begin
                if (accept_s) begin
                    work_nxt_s = rs_i;
                    op_nxt_s   = op_i;
                    cnt_nxt_s  = count_i;
                    cout_nxt_s = 1'b0;
                    // A zero count skips SHIFT, so the operand is returned unchanged.
                    if (count_i == {CNT_W{1'b0}}) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = SHIFT;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SHIFT: begin
                work_nxt_s = step_s[WIDTH-1:0];
                cout_nxt_s = step_s[WIDTH];
                cnt_nxt_s  = cnt_r - CNT_W'(1);
                if (cnt_r == CNT_W'(1)) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = SHIFT;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State and datapath registers. The status flags are registered from the next state.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_r <= IDLE;
            work_r  <= {WIDTH{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            op_r    <= 3'b000;
            cout_r  <= 1'b0;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            work_r  <= work_nxt_s;
            cnt_r   <= cnt_nxt_s;
            op_r    <= op_nxt_s;
            cout_r  <= cout_nxt_s;
            ready_r <= (state_nxt_s != SHIFT);
            busy_r  <= (state_nxt_s == SHIFT);
            done_r  <= (state_nxt_s == DONE);
        end
    end

    assign ready_o = ready_r;
    assign busy_o  = busy_r;
    assign done_o  = done_r;
    assign res_o   = work_r;
    assign cout_o  = cout_r;

endmodule

// File: tb/tb_shift_seq.sv
// -----------------------------------------------------------------------------
// tb_shift_seq
// Self-checking bench for shift_seq (WIDTH=8).
//
// The reference model computes each result directly with integer shift and
// rotate arithmetic. A countdown of remaining cycles predicts ready, busy and
// done. A negedge compare process checks the DUT against the model on every
// cycle. Directed cases check literal results. A randomized phase then mixes
// requests, ignored starts and resets.
// -----------------------------------------------------------------------------
module tb_shift_seq;

    localparam int W    = 8;
    localparam int CW   = 3;
    localparam int MASK = (1 << W) - 1;

    logic          clk = 1'b0;
    logic          rst_ni;
    logic          start_i;
    logic [2:0]    op_i;
    logic [W-1:0]  rs_i;
    logic [CW-1:0] count_i;
    logic          ready_o, busy_o, done_o, cout_o;
    logic [W-1:0]  res_o;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // model state
    bit         m_ready, m_busy, m_done, m_known, m_cout;
    logic [W-1:0] m_res;
    int         m_rem;
    logic [W:0] m_pend;

    shift_seq #(.WIDTH(W)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_ni),
        .start_i (start_i),
        .op_i    (op_i),
        .rs_i    (rs_i),
        .count_i (count_i),
        .ready_o (ready_o),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .res_o   (res_o),
        .cout_o  (cout_o)
    );

    always #5 clk = ~clk;

    // Whole-operation result {cout, res} from plain arithmetic on the operand.
    function automatic logic [W:0] ref_shift(input logic [2:0] op, input logic [W-1:0] rs, input int c);
        int v, sv, r, co, eop;
        v   = int'(rs);
        eop = int'(op);
        if (eop > 4) eop = 0;
`ifndef SHIFT_SEQ_ASR_EN
        if (eop == 4) eop = 0;
`endif
        co = 0;
        r  = v;
        case (eop)
            0: begin r = (v << c) & MASK; if (c > 0) co = (v >> (W - c)) & 1; end
            1: begin r = v >> c;          if (c > 0) co = (v >> (c - 1)) & 1; end
            2: r = ((v << c) | (v >> (W - c))) & MASK;
            3: r = ((v >> c) | (v << (W - c))) & MASK;
            default: begin
                sv = rs[W-1] ? (v - (1 << W)) : v;
                r  = (sv >>> c) & MASK;
                if (c > 0) co = (v >> (c - 1)) & 1;
            end
        endcase
        return {co[0], r[W-1:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model across one rising edge, using the inputs seen at that edge.
    task automatic model_step();
        if (!rst_ni) begin
            m_ready = 1'b1; m_busy = 1'b0; m_done = 1'b0;
            m_res = '0; m_cout = 1'b0; m_known = 1'b1; m_rem = 0;
        end else if (start_i && m_ready) begin
            m_pend = ref_shift(op_i, rs_i, int'(count_i));
            if (count_i == 0) begin
                m_done = 1'b1; m_busy = 1'b0; m_ready = 1'b1;
                {m_cout, m_res} = m_pend; m_known = 1'b1;
            end else begin
                m_rem = int'(count_i);
                m_busy = 1'b1; m_ready = 1'b0; m_done = 1'b0; m_known = 1'b0;
            end
        end else if (m_busy) begin
            m_rem--;
            if (m_rem == 0) begin
                m_busy = 1'b0; m_done = 1'b1; m_ready = 1'b1;
                {m_cout, m_res} = m_pend; m_known = 1'b1;
            end
        end else begin
            m_done = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready", {31'd0, ready_o}, {31'd0, m_ready});
            chk("busy",  {31'd0, busy_o},  {31'd0, m_busy});
            chk("done",  {31'd0, done_o},  {31'd0, m_done});
            if (m_known) begin
                chk("res",  {24'd0, res_o},  {24'd0, m_res});
                chk("cout", {31'd0, cout_o}, {31'd0, m_cout});
            end
        end
    end

    task automatic req(input logic [2:0] op, input logic [7:0] rs, input logic [2:0] cnt);
        start_i = 1'b1; op_i = op; rs_i = rs; count_i = cnt;
    endtask

    initial begin
        rst_ni = 1'b0; start_i = 1'b0; op_i = 3'd0; rs_i = 8'h00; count_i = 3'd0;
        tick();
        chk_en = 1'b1;
        tick();
        chk("rst_ready", {31'd0, ready_o}, 32'd1);
        chk("rst_busy",  {31'd0, busy_o},  32'd0);
        chk("rst_done",  {31'd0, done_o},  32'd0);
        chk("rst_res",   {24'd0, res_o},   32'd0);
        chk("rst_cout",  {31'd0, cout_o},  32'd0);
        rst_ni = 1'b1;
        tick();

        // hand-computed values that pin the reference model
        chk("pin_shl",  {23'd0, ref_shift(3'd0, 8'h81, 1)}, {23'd0, 1'b1, 8'h02});
        chk("pin_ror",  {23'd0, ref_shift(3'd3, 8'h01, 3)}, {23'd0, 1'b0, 8'h20});
        chk("pin_rol",  {23'd0, ref_shift(3'd2, 8'h81, 1)}, {23'd0, 1'b0, 8'h03});
        chk("pin_shr0", {23'd0, ref_shift(3'd1, 8'hA5, 0)}, {23'd0, 1'b0, 8'hA5});
        chk("pin_rsv",  {23'd0, ref_shift(3'd7, 8'h81, 1)}, {23'd0, 1'b1, 8'h02});
`ifdef SHIFT_SEQ_ASR_EN
        chk("pin_asr",  {23'd0, ref_shift(3'd4, 8'h90, 2)}, {23'd0, 1'b0, 8'hE4});
`else
        chk("pin_asr",  {23'd0, ref_shift(3'd4, 8'h90, 2)}, {23'd0, 1'b0, 8'h40});
`endif

        // SHL 0x81 by 1
        req(3'd0, 8'h81, 3'd1);
        tick(); start_i = 1'b0;
        chk("shl_busy", {31'd0, busy_o}, 32'd1);
        tick();
        chk("shl_done", {31'd0, done_o}, 32'd1);
        chk("shl_res",  {24'd0, res_o},  32'h02);
        chk("shl_cout", {31'd0, cout_o}, 32'd1);
        tick();
        chk("shl_pulse", {31'd0, done_o}, 32'd0);
        chk("shl_hold",  {24'd0, res_o},  32'h02);

        // ROR 0x01 by 3, busy for three cycles
        req(3'd3, 8'h01, 3'd3);
        tick(); start_i = 1'b0;
        chk("ror_busy0", {31'd0, busy_o}, 32'd1);
        for (int i = 1; i < 3; i++) begin
            tick();
            chk("ror_busy", {31'd0, busy_o}, 32'd1);
        end
        tick();
        chk("ror_done", {31'd0, done_o}, 32'd1);
        chk("ror_res",  {24'd0, res_o},  32'h20);
        chk("ror_cout", {31'd0, cout_o}, 32'd0);

        // ASR 0x90 by 2
        req(3'd4, 8'h90, 3'd2);
        tick(); start_i = 1'b0;
        tick(); tick();
        chk("asr_done", {31'd0, done_o}, 32'd1);
`ifdef SHIFT_SEQ_ASR_EN
        chk("asr_res",  {24'd0, res_o},  32'hE4);
`else
        chk("asr_res",  {24'd0, res_o},  32'h40);
`endif
        chk("asr_cout", {31'd0, cout_o}, 32'd0);

        // SHR 0xA5 by 0
        req(3'd1, 8'hA5, 3'd0);
        tick(); start_i = 1'b0;
        chk("zero_done", {31'd0, done_o}, 32'd1);
        chk("zero_res",  {24'd0, res_o},  32'hA5);
        chk("zero_cout", {31'd0, cout_o}, 32'd0);
        tick();

        // SHL by 7, start pulsed mid-shift, reset on the 4th shift edge
        req(3'd0, 8'hFF, 3'd7);
        tick(); start_i = 1'b0;
        tick();
        req(3'd1, 8'h12, 3'd1);
        tick(); start_i = 1'b0;
        tick();
        rst_ni = 1'b0;
        tick();
        chk("abort_done",  {31'd0, done_o},  32'd0);
        chk("abort_ready", {31'd0, ready_o}, 32'd1);
        chk("abort_busy",  {31'd0, busy_o},  32'd0);
        chk("abort_res",   {24'd0, res_o},   32'h00);
        rst_ni = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("abort_nodone", {31'd0, done_o}, 32'd0);
        end

        // back-to-back: start held high through DONE
        req(3'd1, 8'h03, 3'd1);
        tick(); tick();
        chk("b2b_done1", {31'd0, done_o}, 32'd1);
        chk("b2b_res1",  {24'd0, res_o},  32'h01);
        tick();
        chk("b2b_busy",  {31'd0, busy_o}, 32'd1);
        tick();
        chk("b2b_done2", {31'd0, done_o}, 32'd1);
        chk("b2b_res2",  {24'd0, res_o},  32'h01);
        chk("b2b_cout2", {31'd0, cout_o}, 32'd1);
        start_i = 1'b0;
        tick();
        chk("b2b_pulse", {31'd0, done_o}, 32'd0);

        // randomized traffic checked by the compare process
        for (int n = 0; n < 1500; n++) begin
            rst_ni  = ($urandom_range(0, 59) != 0);
            start_i = ($urandom_range(0, 1) == 1);
            op_i    = 3'($urandom_range(0, 7));
            rs_i    = 8'($urandom);
            count_i = 3'($urandom_range(0, 7));
            tick();
        end
        rst_ni = 1'b1; start_i = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shift_seq.md
SHIFT_SEQ -- requirements
Module: shift_seq

Interface
REQ-001 Parameter WIDTH, default 8: data width in bits; SHALL be a power of two, at least 4.
REQ-002 Parameter CNT_W, default $clog2(WIDTH): shift-count width; derived from WIDTH, never overridden.
REQ-003 clk_i  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst_ni  input  1  reset; synchronous, active-low.
REQ-005 start_i  input  1  request; accepted only when ready_o=1.
REQ-006 op_i  input  3  operation: 000 SHL, 001 SHR, 010 ROL, 011 ROR, 100 ASR; 101-111 reserved.
REQ-007 rs_i  input  WIDTH  operand, sampled at acceptance.
REQ-008 count_i  input  CNT_W  shift amount, sampled at acceptance.
REQ-009 ready_o  output  1  block can accept a request this cycle.
REQ-010 busy_o  output  1  shift in progress.
REQ-011 done_o  output  1  one-cycle pulse; res_o and cout_o valid this cycle.
REQ-012 res_o  output  WIDTH  result; held from done_o until the next acceptance.
REQ-013 cout_o  output  1  last bit shifted out; held like res_o.

Function
REQ-014 FSM states SHALL be IDLE, SHIFT and DONE.
REQ-015 ready_o SHALL be 1 in IDLE and DONE and 0 in SHIFT; busy_o SHALL be 1 only in SHIFT; done_o SHALL be 1 only in DONE.
REQ-016 Acceptance (start_i & ready_o at an edge, E0) SHALL latch rs_i, op_i and count_i, clear cout_o, and go to SHIFT if count_i!=0, else to DONE.
REQ-017 Each edge in SHIFT SHALL move the working register one position per op_i and decrement the remaining count; the edge that makes it zero SHALL go to DONE.
REQ-018 done_o SHALL be high for exactly the cycle after edge E0+count; total latency is count+1 edges, with 1 edge for count 0.
REQ-019 SHL SHALL shift left with zero fill; cout_o SHALL be the last bit to leave the MSB.
REQ-020 SHR SHALL shift right with zero fill; cout_o SHALL be the last bit to leave the LSB.
REQ-021 ROL and ROR SHALL rotate by count positions; cout_o SHALL be 0.
REQ-022 ASR SHALL shift right, replicating the MSB; cout_o SHALL be the last bit to leave the LSB.
REQ-023 Count 0 SHALL return rs_i unchanged with cout_o=0, for every op.
REQ-024 Reserved op codes SHALL behave as SHL.
REQ-025 start_i during SHIFT SHALL be ignored, with no effect on the operation in progress.
REQ-026 start_i during DONE SHALL be accepted (back-to-back); done_o still pulses for that cycle only.
REQ-027 res_o and cout_o SHALL not change between done_o and the next acceptance.

Reset
REQ-028 rst_ni=0 at an edge SHALL force state IDLE, res_o=0, cout_o=0, done_o=0, busy_o=0, ready_o=1, and clear the remaining count.
REQ-029 Reset SHALL take priority over start_i, and a reset during SHIFT SHALL abandon the operation with no done_o.

Configuration
REQ-030 Macro SHIFT_SEQ_ASR_EN defined: ASR (op 100) SHALL be supported per REQ-022.
REQ-031 Macro SHIFT_SEQ_ASR_EN undefined: op 100 SHALL behave as SHL and no sign-fill logic SHALL be present; all other behaviour is identical.

Verification (WIDTH=8, SHIFT_SEQ_ASR_EN defined unless stated)
REQ-032 SHL, rs=0x81, count=1 -> done_o one cycle after the edge following acceptance; res=0x02, cout=1.
REQ-033 ROR, rs=0x01, count=3 -> res=0x20, cout=0; busy_o high for 3 cycles.
REQ-034 ASR, rs=0x90, count=2 -> res=0xE4, cout=0; with the macro undefined, same stimulus -> res=0x40, cout=0.
REQ-035 SHR, rs=0xA5, count=0 -> done_o the cycle after acceptance; res=0xA5, cout=0.
REQ-036 SHL count=7 accepted, start_i pulsed mid-SHIFT, rst_ni=0 at 4th shift edge -> no done_o, state IDLE, res=0, ready_o=1 the next cycle.
REQ-037 start_i held high in DONE with SHR rs=0x03, count=1 -> back-to-back accept; second done_o gives res=0x01, cout=1.
